// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, frame width, bit-time helper.
// Pure declarations; no latency or flow control of its own.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_MIN_BAUD_PERIOD = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // One bit time in clk cycles for a given programmed period code.
    function automatic logic [31:0] uart_bit_time(input logic [31:0] baud_period);
        return baud_period + 32'd2;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input, resetting to 1 (idle-high pins).
// Latency SYNC_STAGES cycles; no flow control.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with programmable bit time; pin fall to rdy = SYNC_STAGES + H + 9*T + 1 cycles.
// No backpressure: rdy is sticky until clr_rdy, and a byte landing on an unread one raises overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] BAUD_PERIOD,
    input  logic        RX,
    input  logic        clr_rdy,
    output logic [7:0]  rx_data,
    output logic        rdy,
    output logic        framing_err,
    output logic        overrun,
    output logic        busy
);

    localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);

    logic                      rx_s;
    logic                      rx_prev_q,     rx_prev_d;
    uart_rx_state_t            state_q,       state_d;
    logic [31:0]               baud_cnt_q,    baud_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q,       shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q,     rx_data_d;
    logic                      rdy_q,         rdy_d;
    logic                      framing_err_q, framing_err_d;
    logic                      overrun_q,     overrun_d;
    logic                      busy_q,        busy_d;

    logic [31:0] bit_time;
    logic [31:0] full_last;
    logic [31:0] half_last;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    assign bit_time  = uart_bit_time(BAUD_PERIOD);
    assign full_last = bit_time - 32'd1;
    assign half_last = (bit_time >> 1) - 32'd1;

    always_comb begin
        state_d       = state_q;
        rx_prev_d     = rx_s;
        baud_cnt_d    = baud_cnt_q + 32'd1;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rdy_d         = rdy_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;

        if (clr_rdy) begin
            rdy_d         = 1'b0;
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_cnt_q == half_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == full_last) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit re-arms in time for a back-to-back start edge.
                if (baud_cnt_q == full_last) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (rx_s) begin
                        rx_data_d     = shift_q;
                        rdy_d         = 1'b1;
                        framing_err_d = 1'b0;
                        overrun_d     = (overrun_q | rdy_q) & ~clr_rdy;
                    end else begin
                        framing_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_prev_q     <= 1'b1;
            baud_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rdy_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_prev_q     <= rx_prev_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rdy_q         <= rdy_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rdy         = rdy_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the SoC IO subsystem and the receive half of the SoC UART. It synchronizes the `RX` pin and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) using a runtime-programmable bit period. Each byte is presented on a ready/clear handshake to the memory-mapped UART register block. Bit timing matches the SoC transmitter so the two loop back directly.

## Interface
- `SYNC_STAGES`, default 2: number of metastability flops on `RX`; legal values are 2 or 3.
- `clk` input 1: single clock domain.
- `rst_n` input 1: synchronous, active-low reset.
- `BAUD_PERIOD` input 32: bit-time code; one bit time is T = BAUD_PERIOD + 2 clk cycles. Must be held stable while `busy` = 1.
- `RX` input 1: asynchronous serial line; idles high.
- `clr_rdy` input 1: one-cycle pulse from the consumer that acknowledges the byte.
- `rx_data` output 8: last good byte; holds until the next good byte.
- `rdy` output 1: a good byte is available. Sticky until `clr_rdy`.
- `framing_err` output 1: stop bit was sampled low. Sticky until `clr_rdy` or the next good byte.
- `overrun` output 1: a good byte completed while `rdy` was still 1. Sticky until `clr_rdy`.
- `busy` output 1: a frame is in progress (state ≠ IDLE).

## Operation
- **Synchronizer:** `RX` passes through SYNC_STAGES flops, each resetting to 1. `rx_s` is the last stage. `rx_prev` is `rx_s` delayed one cycle.
- **Timing constants:** T = BAUD_PERIOD + 2 and H = T >> 1. Use 32-bit unsigned arithmetic; no overflow is possible for legal values. Minimum legal BAUD_PERIOD is 6 (T = 8). Smaller values are unsupported.
- **Bit counter:** `baud_cnt` is 32 bits and reloads to 0 on every state entry and every sample event.
- **Sample shifting:** each data sample shifts `rx_s` into the MSB of an 8-bit shift register (shift right). After 8 samples, bit 0 holds the first received bit.
- **States:**
  - IDLE: `baud_cnt` is held at 0. When `rx_prev` = 1 and `rx_s` = 0, go to START.
  - START: when `baud_cnt` = H−1, sample `rx_s`. If 1 (false start), go to IDLE. If 0, go to DATA with `bit_cnt` = 0.
  - DATA: when `baud_cnt` = T−1, sample and shift, then increment `bit_cnt`. After the 8th sample, go to STOP.
  - STOP: when `baud_cnt` = T−1, sample and go to IDLE.
    - Sample = 1: load `rx_data` from the shift register, set `rdy`, clear `framing_err`. Set `overrun` if `rdy` was already 1.
    - Sample = 0: set `framing_err` and leave `rx_data`/`rdy` unchanged.
- **Re-arm point:** returning to IDLE at mid-stop-bit lets a start edge arriving immediately after the stop bit be detected.
- **`clr_rdy`:** clears `rdy`, `overrun` and `framing_err` on the next edge.
- **Simultaneous `clr_rdy` and good-byte completion:** the set wins. `rdy` = 1, `overrun` = 0, and `framing_err` is cleared.
- **Simultaneous `clr_rdy` and framing error:** `framing_err` = 1, `rdy` = 0.
- **`clr_rdy` while `rdy` = 0:** no effect other than clearing the flags.

## Timing
- **Reset values:** `rx_data` = 0x00; `rdy`, `framing_err`, `overrun`, `busy` = 0; state = IDLE; sync flops = 1.
- **Reset:** synchronous; `rst_n` low at a posedge forces all reset values on that edge. Reset mid-frame discards the partial byte and does not set any flag.
- **Edge detection:** a pin falling edge is seen as `rx_s` falling SYNC_STAGES cycles later. Call the cycle where `rx_prev` = 1 and `rx_s` = 0 cycle e. `busy` goes high at e+1.
- **Sample instants** (cycles at which `rx_s` is captured):
  - start: e+H
  - data bit i (0..7): e+H+(i+1)·T
  - stop: e+H+9·T
- **Output update:** `rdy`, `rx_data`, `overrun` and `framing_err` change on the edge ending the stop-sample cycle. `busy` falls on that same edge.
- **Latency:** from pin falling edge to `rdy` it is SYNC_STAGES + H + 9·T + 1 cycles.
- **Input rate:** back-to-back frames (next start bit directly after the stop bit) are received with no loss.

## Structure
- **Shared package `uart_pkg`:**
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP as 2-bit encoding.
  - `UART_DATA_BITS` = 8.
  - `UART_MIN_BAUD_PERIOD` = 6.
  - `uart_bit_time(BAUD_PERIOD)` function returning T.
- **Sub-module:** `sync_ff`, a parameterized SYNC_STAGES-deep synchronizer with reset value 1. It is reused for other IO pins.
- **Top-level logic in `uart_rx`:** state register plus combinational next-state logic, `baud_cnt`, `bit_cnt`, the shift register, and the flag registers.

## Test plan
- **Single good byte:** BAUD_PERIOD = 14 (T = 16, H = 8), SYNC_STAGES = 2, drive byte 0xA5 in 8N1 → `rx_data` = 0xA5 and `rdy` = 1 exactly 2+8+144+1 = 155 cycles after the pin falling edge. `framing_err` = 0, `overrun` = 0.
- **False start:** drive a 3-cycle low glitch on `RX` → `busy` pulses high, then returns to IDLE at e+H. `rdy`/`framing_err` stay 0 and `rx_data` is unchanged.
- **Framing error:** drive 0x3C with the stop bit low → `framing_err` = 1, `rdy` = 0, `rx_data` keeps its prior value. A `clr_rdy` pulse then clears `framing_err`.
- **Overrun with `clr_rdy` collision:** send 0x00 then 0xFF back-to-back with no `clr_rdy` → `rx_data` = 0xFF, `rdy` = 1, `overrun` = 1. Repeat with `clr_rdy` asserted in the stop-sample cycle of the second byte → `rdy` = 1, `overrun` = 0.
- **Reset mid-frame:** assert `rst_n` = 0 for one cycle during data bit 4 → all outputs read 0 next cycle. The following frame 0x5A is received correctly.
- **Loopback:** connect the SoC transmitter `TX` to `RX` with BAUD_PERIOD = 0xA2B and send 0x00, 0x55, 0xAA, 0xFF → each value is received in order with no flags set.
